forward_hazard_unit: RTL and testbench

//  Parametrised forwarding/hazard block for the 5-stage RV32I pipeline. Owns E/M/W destination tag

---
 rtl/forward_hazard_unit.sv | 116 +++++++++++
 tb/tb_forward_hazard_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_unit.sv
// Operand forwarding and load-use hazard unit for the 5-stage RV32I pipe; holds E/M/W destination tags.
// Latency: selects, operands and stall/flush are combinational; tags move one cycle per edge unless mem_stall freezes them.
// Backpressure: mem_stall holds every tag and stalls F/D; HAZARD_STATS_EN adds saturating stall/forward counters.
module forward_hazard_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_SRC    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]   rsD,
    input  logic [ADDR_WIDTH-1:0]           rdD,
    input  logic                            reg_writeD,
    input  logic                            is_loadD,
    input  logic                            branch_takenE,
    input  logic                            mem_stall,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   rdataE,
    input  logic [DATA_WIDTH-1:0]           alu_resultM,
    input  logic [DATA_WIDTH-1:0]           resultW,
    output logic [NUM_SRC*DATA_WIDTH-1:0]   operandE,
    output logic [NUM_SRC*2-1:0]            fwd_selE,
    output logic                            stallF,
    output logic                            stallD,
    output logic                            flushE
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]                     stall_cnt,
    output logic [31:0]                     fwd_cnt
`endif
);
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    logic [NUM_SRC*AW-1:0] rs_e;
    logic [AW-1:0]         rd_e, rd_m, rd_w;
    logic                  wr_e, ld_e, wr_m, ld_m, wr_w;
    logic                  load_use;
    logic                  bubble_e;

    // A load to x0 produces nothing a consumer could wait for.
    always_comb begin
        load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ld_e && wr_e && (rd_e != '0) && (rsD[i*AW +: AW] == rd_e))
                load_use = 1'b1;
        end
    end

    always_comb begin
        fwd_selE = '0;
        operandE = rdataE;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rs_e[i*AW +: AW] != '0) begin
                if (wr_m && !ld_m && (rd_m == rs_e[i*AW +: AW])) begin
                    fwd_selE[i*2 +: 2]  = 2'b10;
                    operandE[i*DW +: DW] = alu_resultM;
                end else if (wr_w && (rd_w == rs_e[i*AW +: AW])) begin
                    fwd_selE[i*2 +: 2]  = 2'b01;
                    operandE[i*DW +: DW] = resultW;
                end
            end
        end
    end

    // Redirect kills the D instruction, so a pending load-use stall is moot.
    assign stallF   = !rst && (mem_stall || (!branch_takenE && load_use));
    assign stallD   = stallF;
    assign flushE   = !rst && !mem_stall && (branch_takenE || load_use);
    assign bubble_e = branch_takenE || load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_e <= '0;
            rd_e <= '0;
            wr_e <= 1'b0;
            ld_e <= 1'b0;
            rd_m <= '0;
            wr_m <= 1'b0;
            ld_m <= 1'b0;
            rd_w <= '0;
            wr_w <= 1'b0;
        end else if (!mem_stall) begin
            rd_w <= rd_m;
            wr_w <= wr_m;
            rd_m <= rd_e;
            wr_m <= wr_e;
            ld_m <= ld_e;
            if (bubble_e) begin
                rs_e <= '0;
                rd_e <= '0;
                wr_e <= 1'b0;
                ld_e <= 1'b0;
            end else begin
                rs_e <= rsD;
                rd_e <= rdD;
                wr_e <= reg_writeD;
                ld_e <= is_loadD;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (!mem_stall) begin
            if (load_use && !branch_takenE && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
            if ((|fwd_selE) && (fwd_cnt != 32'hFFFF_FFFF))
                fwd_cnt <= fwd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: reset check, directed cycle table, then randomized run against an instruction-level model.
module tb_forward_hazard_unit;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NS*AW-1:0]    rsD;
    logic [AW-1:0]       rdD;
    logic                reg_writeD, is_loadD, branch_takenE, mem_stall;
    logic [NS*DW-1:0]    rdataE;
    logic [DW-1:0]       alu_resultM, resultW;
    logic [NS*DW-1:0]    operandE;
    logic [NS*2-1:0]     fwd_selE;
    logic                stallF, stallD, flushE;
`ifdef HAZARD_STATS_EN
    logic [31:0]         stall_cnt, fwd_cnt;
    int                  exp_stall = 0;
    int                  exp_fwd = 0;
`endif

    forward_hazard_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SRC(NS)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rdD(rdD), .reg_writeD(reg_writeD),
        .is_loadD(is_loadD), .branch_takenE(branch_takenE), .mem_stall(mem_stall),
        .rdataE(rdataE), .alu_resultM(alu_resultM), .resultW(resultW),
        .operandE(operandE), .fwd_selE(fwd_selE), .stallF(stallF), .stallD(stallD),
        .flushE(flushE)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic r, input logic [AW-1:0] s0, s1, d, input logic w, l, b, m,
                         input logic [DW-1:0] r0, r1, am, rw);
        rst = r; rsD = {s1, s0}; rdD = d; reg_writeD = w; is_loadD = l;
        branch_takenE = b; mem_stall = m; rdataE = {r1, r0}; alu_resultM = am; resultW = rw;
    endtask

    task automatic check_all(input string tag, input logic [1:0] es0, es1,
                             input logic [DW-1:0] eo0, eo1, input logic esf, efl);
        chk({tag, " sel0"}, 64'(fwd_selE[1:0]), 64'(es0));
        chk({tag, " sel1"}, 64'(fwd_selE[3:2]), 64'(es1));
        chk({tag, " op0"}, 64'(operandE[DW-1:0]), 64'(eo0));
        chk({tag, " op1"}, 64'(operandE[2*DW-1:DW]), 64'(eo1));
        chk({tag, " stallF"}, 64'(stallF), 64'(esf));
        chk({tag, " stallD"}, 64'(stallD), 64'(esf));
        chk({tag, " flushE"}, 64'(flushE), 64'(efl));
`ifdef HAZARD_STATS_EN
        chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'(exp_stall));
        chk({tag, " fwd_cnt"}, 64'(fwd_cnt), 64'(exp_fwd));
`endif
    endtask

    // One row = one cycle: D-stage inputs plus the outputs expected before the next edge.
    typedef struct {
        logic [AW-1:0] rs0, rs1, rd;
        logic          wr, ld, br, ms;
        logic [DW-1:0] alum;
        logic [1:0]    s0, s1;
        logic [DW-1:0] o0, o1;
        logic          sf, fl;
    } vec_t;

    function automatic vec_t mk(input logic [AW-1:0] rs0, rs1, rd, input logic wr, ld, br, ms,
                                input logic [DW-1:0] alum, input logic [1:0] s0, s1,
                                input logic [DW-1:0] o0, o1, input logic sf, fl);
        vec_t v;
        v.rs0 = rs0; v.rs1 = rs1; v.rd = rd; v.wr = wr; v.ld = ld; v.br = br; v.ms = ms;
        v.alum = alum; v.s0 = s0; v.s1 = s1; v.o0 = o0; v.o1 = o1; v.sf = sf; v.fl = fl;
        return v;
    endfunction

    // Instruction-level reference model of the E/M/W occupants.
    typedef struct {
        int rs[NS];
        int rd;
        bit wr;
        bit ld;
    } ins_t;

    ins_t mE, mM, mW, nop_i;

    function automatic int msel(input int rs);
        if (rs == 0) return 0;
        if (mM.wr && !mM.ld && mM.rd == rs) return 2;
        if (mW.wr && mW.rd == rs) return 1;
        return 0;
    endfunction

    vec_t vt[24];

    initial begin
        localparam logic [DW-1:0] R0 = 32'h11, R1 = 32'h22, A = 32'hA, B = 32'hB;
        nop_i.rs[0] = 0; nop_i.rs[1] = 0; nop_i.rd = 0; nop_i.wr = 0; nop_i.ld = 0;

        vt[0]  = mk(1, 2, 5, 1, 0, 0, 0, A,           2'b00, 2'b00, R0, R1, 0, 0);
        vt[1]  = mk(5, 1, 6, 1, 0, 0, 0, A,           2'b00, 2'b00, R0, R1, 0, 0);
        vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h1234,    2'b10, 2'b00, 32'h1234, R1, 0, 0);
        vt[3]  = mk(0, 0, 5, 1, 0, 0, 0, A,           2'b00, 2'b00, R0, R1, 0, 0);
        vt[4]  = mk(0, 0, 5, 1, 0, 0, 0, A,           2'b00, 2'b00, R0, R1, 0, 0);
        vt[5]  = mk(5, 1, 8, 1, 0, 0, 0, A,           2'b00, 2'b00, R0, R1, 0, 0);
        vt[6]  = mk(5, 8, 9, 1, 0, 0, 0, A,           2'b10, 2'b00, A,  R1, 0, 0);
        vt[7]  = mk(1, 0, 7, 1, 1, 0, 0, A,           2'b01, 2'b10, B,  A,  0, 0);
        vt[8]  = mk(7, 0, 10, 1, 0, 0, 0, A,          2'b00, 2'b00, R0, R1, 1, 1);
        vt[9]  = mk(7, 0, 10, 1, 0, 0, 0, A,          2'b00, 2'b00, R0, R1, 0, 0);
        vt[10] = mk(0, 0, 0, 0, 0, 0, 0, A,           2'b01, 2'b00, B,  R1, 0, 0);
        vt[11] = mk(0, 0, 7, 1, 1, 0, 0, A,           2'b00, 2'b00, R0, R1, 0, 0);
        vt[12] = mk(7, 0, 12, 1, 0, 1, 0, A,          2'b00, 2'b00, R0, R1, 0, 1);
        vt[13] = mk(1, 1, 0, 1, 0, 0, 0, A,           2'b00, 2'b00, R0, R1, 0, 0);
        vt[14] = mk(0, 1, 11, 1, 0, 0, 0, A,          2'b00, 2'b00, R0, R1, 0, 0);
        vt[15] = mk(0, 0, 0, 0, 0, 0, 0, A,           2'b00, 2'b00, R0, R1, 0, 0);
        vt[16] = mk(0, 0, 0, 1, 1, 0, 0, A,           2'b00, 2'b00, R0, R1, 0, 0);
        vt[17] = mk(0, 2, 3, 1, 0, 0, 0, A,           2'b00, 2'b00, R0, R1, 0, 0);
        vt[18] = mk(3, 3, 4, 1, 0, 0, 0, A,           2'b00, 2'b00, R0, R1, 0, 0);
        vt[19] = mk(0, 0, 0, 0, 0, 0, 1, A,           2'b10, 2'b10, A,  A,  1, 0);
        vt[20] = mk(0, 0, 0, 0, 0, 0, 1, A,           2'b10, 2'b10, A,  A,  1, 0);
        vt[21] = mk(0, 0, 0, 0, 0, 0, 1, A,           2'b10, 2'b10, A,  A,  1, 0);
        vt[22] = mk(0, 0, 0, 0, 0, 0, 0, A,           2'b10, 2'b10, A,  A,  0, 0);
        vt[23] = mk(0, 0, 0, 0, 0, 0, 0, A,           2'b00, 2'b00, R0, R1, 0, 0);

        // Reset with a hazard-looking D instruction present.
        drive(1, 5, 5, 5, 1, 1, 0, 0, 32'hCAFE, 32'hBEEF, A, B);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 2'b00, 2'b00, 32'hCAFE, 32'hBEEF, 0, 0);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(0, vt[i].rs0, vt[i].rs1, vt[i].rd, vt[i].wr, vt[i].ld, vt[i].br, vt[i].ms,
                  R0, R1, vt[i].alum, B);
            #1;
            check_all($sformatf("row%0d", i), vt[i].s0, vt[i].s1, vt[i].o0, vt[i].o1,
                      vt[i].sf, vt[i].fl);
            @(posedge clk);
`ifdef HAZARD_STATS_EN
            if (!vt[i].ms) begin
                if (vt[i].sf && vt[i].fl) exp_stall++;
                if (vt[i].s0 != 2'b00 || vt[i].s1 != 2'b00) exp_fwd++;
            end
`endif
        end

        // Randomized phase; first cycle forces a reset so the model starts from an empty pipe.
        for (int c = 0; c < 600; c++) begin
            logic r, w, l, b, m, lu, any;
            logic [AW-1:0] s[NS];
            logic [AW-1:0] d;
            logic [DW-1:0] rv[NS];
            logic [DW-1:0] am, rw;
            logic [1:0] es[NS];
            logic [DW-1:0] eo[NS];
            @(negedge clk);
            r = (c == 0) || ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NS; i++) begin
                s[i] = AW'($urandom_range(0, 4));
                rv[i] = $urandom;
            end
            d = AW'($urandom_range(0, 4));
            w = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 9) == 0);
            m = ($urandom_range(0, 19) < 3);
            am = $urandom;
            rw = $urandom;
            drive(r, s[0], s[1], d, w, l, b, m, rv[0], rv[1], am, rw);
            #1;
            lu = 0;
            any = 0;
            for (int i = 0; i < NS; i++) begin
                if (mE.ld && mE.wr && mE.rd != 0 && int'(s[i]) == mE.rd) lu = 1;
                case (msel(mE.rs[i]))
                    2: begin es[i] = 2'b10; eo[i] = am; end
                    1: begin es[i] = 2'b01; eo[i] = rw; end
                    default: begin es[i] = 2'b00; eo[i] = rv[i]; end
                endcase
                if (es[i] != 2'b00) any = 1;
            end
            if (!r)
                check_all($sformatf("rnd%0d", c), es[0], es[1], eo[0], eo[1],
                          m ? 1'b1 : (b ? 1'b0 : lu), m ? 1'b0 : (b || lu));
            @(posedge clk);
            if (r) begin
                mE = nop_i; mM = nop_i; mW = nop_i;
`ifdef HAZARD_STATS_EN
                exp_stall = 0; exp_fwd = 0;
`endif
            end else if (!m) begin
`ifdef HAZARD_STATS_EN
                if (lu && !b) exp_stall++;
                if (any) exp_fwd++;
`endif
                mW = mM;
                mM = mE;
                if (b || lu) mE = nop_i;
                else begin
                    for (int i = 0; i < NS; i++) mE.rs[i] = int'(s[i]);
                    mE.rd = int'(d); mE.wr = w; mE.ld = l;
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
